store_buffer: RTL and testbench

- Posted-write buffer between the accumulator store path and data memory.
- The core issues a store (address plus accumulator value) with a valid/ready handshake. The block queues it in a small FIFO and drains it into data memory one write per cycle, stalling while memory signals busy.
- It is the write-side counterpart of the accumulator load-select path: the accumulator is read out to memory here, rather than written from memory.

---
 rtl/store_buffer.sv | 136 +++++++++++++
 tb/tb_store_buffer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the accumulator store path and data
// memory. Stores are accepted with a valid/ready handshake, queued, and
// drained to memory one registered write per cycle unless memory is busy.
// Optional feature macro: STORE_BUFFER_FWD_EN enables store-to-load forwarding.
// Handshake: a store transfers at a rising edge when st_valid=1 and st_ready=1;
// st_ready depends only on the current occupancy, and the core must hold
// st_valid/st_addr/st_data stable until the transfer happens.
module store_buffer #(
  parameter int DATA_WIDTH = 11,
  parameter int ADDR_WIDTH = 11,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic                  mem_busy,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  output logic                  fwd_hit,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic                  empty
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int COUNT_W = $clog2(DEPTH + 1);

  // Entry storage; validity is implied by rd_ptr/count, so it needs no reset.
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0]    count_q, count_d;
  logic                  mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;

  logic push;
  logic pop;

  // Full is decided by the occupancy count alone, never by a same-cycle pop.
  assign st_ready  = (count_q != COUNT_W'(DEPTH));
  assign push      = st_valid & st_ready;
  assign pop       = (count_q != '0) & ~mem_busy;

  assign mem_wr_en = mem_wr_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign empty     = (count_q == '0) & ~mem_wr_en_q;

  // Next-state: pointer advance, occupancy update and output register load.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    mem_wr_en_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      mem_wr_en_d = 1'b1;
      mem_addr_d  = addr_mem[rd_ptr_q];
      mem_data_d  = data_mem[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + COUNT_W'(1);
      2'b01:   count_d = count_q - COUNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mem_wr_en_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
    end
  end

  // Entry write on an accepted store.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= st_addr;
      data_mem[wr_ptr_q] <= st_data;
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Youngest-match lookup: scan oldest to newest so later matches win; the
  // in-flight output register is the oldest candidate and is checked first.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    if (mem_wr_en_q && (mem_addr_q == ld_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = mem_data_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PTR_W'(i);
      if ((COUNT_W'(i) < count_q) && (addr_mem[fwd_idx] == ld_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[fwd_idx];
      end
    end
  end
`else
  // Forwarding disabled: outputs tied off, load address unused.
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
  logic unused_ld;
  assign unused_ld = ^ld_addr;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed test of store_buffer with a write-order scoreboard.
module tb_store_buffer;

  localparam int DW = 11;
  localparam int AW = 11;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          mem_busy;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [AW-1:0] ld_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic          empty;

  int n_total = 0;
  int n_bad   = 0;
  int n_writes = 0;

  logic [AW+DW-1:0] exp_q[$];

  store_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .mem_busy(mem_busy), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .ld_addr(ld_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .empty(empty)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: writes must match accepted stores in order; reset flushes.
  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        check("write_order", 32'({mem_addr, mem_data}), 32'(exp_q.pop_front()));
      end
    end
    if (reset === 1'b1) begin
      exp_q.delete();
    end else if (st_valid === 1'b1 && st_ready === 1'b1) begin
      exp_q.push_back({st_addr, st_data});
    end
  end

  task automatic wait_empty(input string tag);
    int cyc = 0;
    while (!(empty === 1'b1) && cyc < 50) begin
      tick();
      cyc++;
    end
    check(tag, 32'(empty), 32'd1);
  endtask

  initial begin
    int w0;
    int pushed;
    int cyc;
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
    mem_busy = 1'b0; ld_addr = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_st_ready", 32'(st_ready), 32'd1);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", 32'(mem_data), 32'd0);
    check("rst_fwd_hit", 32'(fwd_hit), 32'd0);
    check("rst_fwd_data", 32'(fwd_data), 32'd0);

    // Single store latency
    st_valid = 1'b1; st_addr = 11'h005; st_data = 11'h2A3;
    tick();                       // accepted at edge N
    st_valid = 1'b0;
    check("lat_n1_wr_en", 32'(mem_wr_en), 32'd0);
    check("lat_n1_empty", 32'(empty), 32'd0);
    tick();                       // issue at edge N+1
    check("lat_n2_wr_en", 32'(mem_wr_en), 32'd1);
    check("lat_n2_addr", 32'(mem_addr), 32'h005);
    check("lat_n2_data", 32'(mem_data), 32'h2A3);
    tick();
    check("lat_n3_wr_en", 32'(mem_wr_en), 32'd0);
    check("lat_n3_empty", 32'(empty), 32'd1);
    check("lat_n3_addr_hold", 32'(mem_addr), 32'h005);

    // Five stores against a busy memory; full, then pop with refused push
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      st_valid = 1'b1; st_addr = 11'(32'h100 + i); st_data = 11'(32'h010 + i);
      check("fill_ready", 32'(st_ready), 32'd1);
      tick();
    end
    st_addr = 11'h104; st_data = 11'h014;
    check("full_ready", 32'(st_ready), 32'd0);
    tick(); tick();
    check("busy_no_write", 32'(mem_wr_en), 32'd0);
    check("busy_still_full", 32'(st_ready), 32'd0);
    w0 = n_writes;
    mem_busy = 1'b0;
    check("full_pop_refuse", 32'(st_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("drain_stream", 32'(mem_wr_en), 32'd1);
      if (k == 0) check("ready_after_pop", 32'(st_ready), 32'd1);
      if (k == 1) st_valid = 1'b0;
    end
    tick();
    check("drain_done_wr_en", 32'(mem_wr_en), 32'd0);
    check("drain_done_empty", 32'(empty), 32'd1);
    check("drain_count", 32'(n_writes - w0), 32'd5);

    // Wrap: ten stores with alternating busy, including repeated addresses
    w0 = n_writes;
    pushed = 0;
    cyc = 0;
    while (pushed < 10 && cyc < 200) begin
      mem_busy = cyc[0];
      st_valid = 1'b1;
      st_addr = 11'(32'h200 + (pushed % 3));
      st_data = 11'((pushed * 32'h45 + 7) & 32'h7FF);
      if (st_ready) pushed++;
      tick();
      cyc++;
    end
    st_valid = 1'b0;
    check("wrap_pushed", 32'(pushed), 32'd10);
    mem_busy = 1'b0;
    wait_empty("wrap_empty");
    check("wrap_count", 32'(n_writes - w0), 32'd10);
    check("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

    // Forwarding lookup (or tie-off when disabled)
    mem_busy = 1'b1;
    st_valid = 1'b1; st_addr = 11'h010; st_data = 11'h111;
    tick();
    st_data = 11'h222;
    tick();
    st_valid = 1'b0;
    ld_addr = 11'h010;
    #1;
`ifdef STORE_BUFFER_FWD_EN
    check("fwd_hit", 32'(fwd_hit), 32'd1);
    check("fwd_data_young", 32'(fwd_data), 32'h222);
    ld_addr = 11'h011;
    #1;
    check("fwd_miss", 32'(fwd_hit), 32'd0);
`else
    check("fwd_off_hit", 32'(fwd_hit), 32'd0);
    check("fwd_off_data", 32'(fwd_data), 32'd0);
`endif
    ld_addr = '0;
    mem_busy = 1'b0;
    wait_empty("fwd_drain_empty");

    // Reset with three entries queued and a write in flight
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      st_valid = 1'b1; st_addr = 11'(32'h300 + i); st_data = 11'(32'h0A0 + i);
      tick();
    end
    st_valid = 1'b0;
    mem_busy = 1'b0;
    tick();
    check("pre_rst_wr_en", 32'(mem_wr_en), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_ready", 32'(st_ready), 32'd1);
    w0 = n_writes;
    for (int k = 0; k < 6; k++) tick();
    check("post_rst_no_writes", 32'(n_writes - w0), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Run-time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
